// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multi-digit seven-segment scan driver with frame-aligned value updates
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    i_clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    output logic                    o_Seg_A,
    output logic                    o_Seg_B,
    output logic                    o_Seg_C,
    output logic                    o_Seg_D,
    output logic                    o_Seg_E,
    output logic                    o_Seg_F,
    output logic                    o_Seg_G,
    output logic [NUM_DIGITS-1:0]   o_Dig,
    output logic                    o_frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_DRIVE = 1'b1;

    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] SLOT_END  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic                    state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    frame_start_q, frame_start_d;

    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    lead_zero;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'b1111110;
            4'h1:    hex_decode = 7'b0110000;
            4'h2:    hex_decode = 7'b1101101;
            4'h3:    hex_decode = 7'b1111001;
            4'h4:    hex_decode = 7'b0110011;
            4'h5:    hex_decode = 7'b1011011;
            4'h6:    hex_decode = 7'b1011111;
            4'h7:    hex_decode = 7'b1110000;
            4'h8:    hex_decode = 7'b1111111;
            4'h9:    hex_decode = 7'b1111011;
            4'hA:    hex_decode = 7'b1110111;
            4'hB:    hex_decode = 7'b0011111;
            4'hC:    hex_decode = 7'b1001110;
            4'hD:    hex_decode = 7'b0111101;
            4'hE:    hex_decode = 7'b1001111;
            default: hex_decode = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (state_q == ST_BLANK) begin
            if (cnt_d == BLANK_END) state_d = ST_DRIVE;
        end else if (cnt_q == SLOT_END) begin
            state_d  = ST_BLANK;
            cnt_d    = '0;
            boundary = (idx_q == IDX_LAST);
            idx_d    = boundary ? '0 : idx_q + 1'b1;
        end
    end

    // Transfer uses the pre-edge staging value; a coincident load re-arms pending.
    always_comb begin
        staging_d = staging_q;
        pending_d = pending_q;
        display_d = display_q;
        if (boundary && pending_q) begin
            display_d = staging_q;
            pending_d = 1'b0;
        end
        if (i_load) begin
            staging_d = i_value;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IW'(k)) cur_nib = display_q[4*k +: 4];
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead_zero = (idx_d != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) >= idx_d && display_q[4*k +: 4] != 4'h0) lead_zero = 1'b0;
        end
`else
        lead_zero = 1'b0;
`endif
    end

    // Outputs are computed from the next state so they change on the transition edge.
    always_comb begin
        seg_d         = '0;
        dig_d         = '0;
        frame_start_d = boundary;
        if (state_d == ST_DRIVE) begin
            dig_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
            if (!lead_zero) seg_d = hex_decode(cur_nib);
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            staging_q     <= '0;
            display_q     <= '0;
            pending_q     <= 1'b0;
            seg_q         <= '0;
            dig_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            staging_q     <= staging_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign {o_Seg_A, o_Seg_B, o_Seg_C, o_Seg_D, o_Seg_E, o_Seg_F, o_Seg_G} = seg_q;
    assign o_Dig         = dig_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux (4 digits, 10-cycle slots, 2-cycle blank)
module tb_seg7_scan_mux;
    localparam int ND    = 4;
    localparam int DIV   = 10;
    localparam int BLK   = 2;
    localparam int FRAME = ND * DIV;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        i_load  = 1'b0;
    logic [15:0] i_value = 16'h0;
    logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [3:0]  dig;
    logic        fs;
    logic [6:0]  seg;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;
    int          load_edge[$];
    logic [15:0] load_val[$];

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .i_clk(clk), .rst_n(rst_n), .i_load(i_load), .i_value(i_value),
        .o_Seg_A(seg_a), .o_Seg_B(seg_b), .o_Seg_C(seg_c), .o_Seg_D(seg_d),
        .o_Seg_E(seg_e), .o_Seg_F(seg_f), .o_Seg_G(seg_g),
        .o_Dig(dig), .o_frame_start(fs)
    );

    assign seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Value on display during the frame containing edge n: last load strictly before that frame's boundary edge.
    function automatic logic [15:0] shown_value(input int n);
        int          fb = n - (n % FRAME);
        logic [15:0] v  = 16'h0;
        if (fb > 0) begin
            foreach (load_edge[i]) if (load_edge[i] < fb) v = load_val[i];
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_dig(input int n);
        int p = n % FRAME;
        if (n == 0 || (p % DIV) < BLK) return 4'b0000;
        return 4'b0001 << (p / DIV);
    endfunction

    function automatic logic [6:0] exp_seg(input int n);
        int          p = n % FRAME;
        int          d = p / DIV;
        logic [15:0] v;
        if (n == 0 || (p % DIV) < BLK) return 7'b0;
        v = shown_value(n) >> (4 * d);
        if (LZ && d > 0 && v == 16'h0) return 7'b0;
        return seg_tab[v[3:0]];
    endfunction

    function automatic logic exp_fs(input int n);
        return (n > 0) && (n % FRAME == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0;
            load_edge.delete();
            load_val.delete();
        end else begin
            edge_n++;
            if (i_load) begin
                load_edge.push_back(edge_n);
                load_val.push_back(i_value);
            end
        end
    end

    always @(negedge clk) begin
        check("model_dig", dig, exp_dig(edge_n));
        check("model_seg", seg, exp_seg(edge_n));
        check("model_frame_start", fs, exp_fs(edge_n));
    end

    task automatic wait_fs();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (fs) return;
        end
        check("timeout_frame_start", 0, 1);
    endtask

    task automatic wait_dig(input logic [3:0] target);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (dig == target) return;
        end
        check("timeout_dig", 0, 1);
    endtask

    task automatic expect_digit(input string name, input logic [3:0] target, input logic [6:0] exp);
        wait_dig(target);
        check(name, seg, exp);
    endtask

    task automatic load(input logic [15:0] v);
        i_value = v;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
    endtask

    task automatic post_release_scan();
        check("release_dig", dig, 4'b0000);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("release_scan_dig", dig, (i >= 2 && i <= 9) ? 4'b0001 : 4'b0000);
        end
    endtask

    initial begin
        int pulses;
        int multi;
        int on_cnt[4];

        #1 rst_n = 1'b0;
        #1;
        check("reset_dig", dig, 4'b0000);
        check("reset_seg", seg, 7'b0);
        check("reset_fs", fs, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        post_release_scan();

        wait_fs();
        pulses = 0;
        multi  = 0;
        on_cnt = '{0, 0, 0, 0};
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            pulses += int'(fs);
            for (int k = 0; k < 4; k++) on_cnt[k] += int'(dig[k]);
            if ($countones(dig) > 1) multi++;
        end
        check("free_run_pulses", pulses, 3);
        check("free_run_multi_hot", multi, 0);
        for (int k = 0; k < 4; k++) check("free_run_dig_on", on_cnt[k], 24);

        repeat (5) @(negedge clk);
        load(16'h1234);
        expect_digit("cur_frame_d1", 4'b0010, 7'b1111110);
        wait_fs();
        expect_digit("v1234_d0", 4'b0001, 7'b0110011);
        expect_digit("v1234_d1", 4'b0010, 7'b1111001);
        expect_digit("v1234_d2", 4'b0100, 7'b1101101);
        expect_digit("v1234_d3", 4'b1000, 7'b0110000);

        wait_fs();
        repeat (3) @(negedge clk);
        load(16'h1111);
        repeat (10) @(negedge clk);
        load(16'hABCD);
        wait_fs();
        expect_digit("vABCD_d0", 4'b0001, 7'b0111101);
        expect_digit("vABCD_d1", 4'b0010, 7'b1001110);
        expect_digit("vABCD_d2", 4'b0100, 7'b0011111);
        expect_digit("vABCD_d3", 4'b1000, 7'b1110111);

        repeat (7) @(negedge clk);
        i_value = 16'h5555;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
        check("coincident_fs", fs, 1'b1);
        expect_digit("coincident_prior_d0", 4'b0001, 7'b0111101);
        expect_digit("coincident_prior_d3", 4'b1000, 7'b1110111);
        wait_fs();
        expect_digit("v5555_d0", 4'b0001, 7'b1011011);
        expect_digit("v5555_d1", 4'b0010, 7'b1011011);
        expect_digit("v5555_d2", 4'b0100, 7'b1011011);
        expect_digit("v5555_d3", 4'b1000, 7'b1011011);

        wait_dig(4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_dig", dig, 4'b0000);
        check("async_reset_seg", seg, 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        post_release_scan();

        load(16'h0005);
        wait_fs();
        expect_digit("v0005_d0", 4'b0001, 7'b1011011);
        expect_digit("v0005_d1", 4'b0010, LZ ? 7'b0 : 7'b1111110);
        expect_digit("v0005_d2", 4'b0100, LZ ? 7'b0 : 7'b1111110);
        expect_digit("v0005_d3", 4'b1000, LZ ? 7'b0 : 7'b1111110);
        load(16'h0000);
        wait_fs();
        expect_digit("v0000_d0", 4'b0001, 7'b1111110);
        expect_digit("v0000_d1", 4'b0010, LZ ? 7'b0 : 7'b1111110);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
